// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: issues one instruction-memory request at a time,
// registers the returned word and handles jump/branch redirects, including those
// that arrive while a request is still in flight.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INC          = 32'd4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Enable,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPc,
    output logic        AddrError
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    state_e      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        valid_q,       valid_d;
    logic        req_q,         req_d;
    logic        addr_err_q,    addr_err_d;
    logic        pend_q,        pend_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        redirect_s;
    logic [31:0] raw_target_s;
    logic [31:0] target_s;
    logic        misaligned_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Redirect arbitration: jump has priority over a taken branch.
    always_comb begin
        redirect_s   = Jump | BranchTaken;
        raw_target_s = 32'h0000_0000;
        if (Jump) begin
            raw_target_s = JumpTarget;
        end else begin
            raw_target_s = BranchTarget;
        end
        target_s     = word_align(raw_target_s);
        misaligned_s = redirect_s & is_misaligned(raw_target_s);
    end

    // Next-state, PC and fetched-instruction update logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        addr_err_d    = misaligned_s;

        case (state_q)
            ST_IDLE: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    state_d = ST_IDLE;
                end else if (Enable) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_FETCH: begin
                // Address stays on pc_q until the ack; a stale response is dropped.
                if (ImemAck) begin
                    if (redirect_s) begin
                        pc_d    = target_s;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else if (pend_q) begin
                        pc_d    = pend_target_q;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end else begin
                        instr_d    = ImemData;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + INC;
                        state_d    = ST_VALID;
                    end
                end else begin
                    if (redirect_s) begin
                        pend_d        = 1'b1;
                        pend_target_d = target_s;
                    end else begin
                        pend_d        = pend_q;
                    end
                end
            end

            ST_VALID: begin
                if (redirect_s) begin
                    pc_d = target_s;
                    if (Enable) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!Stall) begin
                    if (Enable) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase

        req_d   = (state_d == ST_FETCH);
        valid_d = (state_d == ST_VALID);
    end

    // State and output registers; reset abandons any outstanding request.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            valid_q       <= 1'b0;
            req_q         <= 1'b0;
            addr_err_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            valid_q       <= valid_d;
            req_q         <= req_d;
            addr_err_q    <= addr_err_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign ImemReq    = req_q;
    assign ImemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign InstrPc    = instr_pc_q;
    assign AddrError  = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: one task per scenario, inline checks,
// plus a second instance with a wrapping reset vector.
module tb_pc_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Enable = 1'b0;
    logic        Stall = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'h0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        ImemAck = 1'b0;
    logic [31:0] ImemData = 32'h0;

    logic        ImemReq, InstrValid, AddrError;
    logic [31:0] ImemAddr, Instr, InstrPc;
    logic        ImemReq_b, InstrValid_b, AddrError_b;
    logic [31:0] ImemAddr_b, Instr_b, InstrPc_b;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer dut (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Stall(Stall),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .InstrValid(InstrValid), .Instr(Instr), .InstrPc(InstrPc), .AddrError(AddrError)
    );

    pc_fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC), .INC(32'd4)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Enable(Enable), .Stall(Stall),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .ImemReq(ImemReq_b), .ImemAddr(ImemAddr_b), .ImemAck(ImemAck), .ImemData(ImemData),
        .InstrValid(InstrValid_b), .Instr(Instr_b), .InstrPc(InstrPc_b), .AddrError(AddrError_b)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0; Enable = 1'b0; Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
        ImemAck = 1'b0; ImemData = 32'h0; JumpTarget = 32'h0; BranchTarget = 32'h0;
        #1;
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", ImemReq); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", ImemAddr); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", InstrValid); end
        checks++; if (Instr !== 32'h0 || InstrPc !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h/%h want 0/0", Instr, InstrPc); end
        checks++; if (AddrError !== 1'b0) begin errors++; $display("FAIL rst_adderr: got %0b want 0", AddrError); end
        checks++; if (ImemAddr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr_b: got %h want fffffffc", ImemAddr_b); end
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst_n = 1'b1;
        tick();
        tick();
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_idle_no_enable: got %0b want 0", ImemReq); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_data;
        apply_reset();
        Enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ImemAck = 1'b0;
            tick();
            checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'(4 * i)) begin errors++; $display("FAIL seq_fetch%0d: got req=%0b addr=%h want 1/%h", i, ImemReq, ImemAddr, 32'(4 * i)); end
            checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL seq_fetch_valid%0d: got %0b want 0", i, InstrValid); end
            exp_data = 32'hC0DE_0000 + 32'(i);
            ImemAck  = 1'b1;
            ImemData = exp_data;
            tick();
            checks++; if (InstrValid !== 1'b1 || ImemReq !== 1'b0) begin errors++; $display("FAIL seq_valid%0d: got valid=%0b req=%0b want 1/0", i, InstrValid, ImemReq); end
            checks++; if (InstrPc !== 32'(4 * i) || Instr !== exp_data) begin errors++; $display("FAIL seq_instr%0d: got pc=%h instr=%h want %h/%h", i, InstrPc, Instr, 32'(4 * i), exp_data); end
        end
        ImemAck = 1'b0;
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (InstrValid !== 1'b1 || InstrPc !== 32'h8 || Instr !== 32'hC0DE_0002) begin errors++; $display("FAIL stall_hold%0d: got v=%0b pc=%h instr=%h want 1/00000008/c0de0002", i, InstrValid, InstrPc, Instr); end
            checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %0b want 0", i, ImemReq); end
        end
        Stall = 1'b0;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hC || InstrValid !== 1'b0) begin errors++; $display("FAIL stall_release: got req=%0b addr=%h v=%0b want 1/0000000c/0", ImemReq, ImemAddr, InstrValid); end
    endtask

    task automatic test_jump_pending();
        apply_reset();
        Enable = 1'b1;
        tick();
        ImemAck = 1'b1; ImemData = 32'h1000_0000;
        tick();
        ImemAck = 1'b0;
        tick();
        ImemAck = 1'b1; ImemData = 32'h1000_0004;
        tick();
        ImemAck = 1'b0;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin errors++; $display("FAIL jp_fetch8: got req=%0b addr=%h want 1/00000008", ImemReq, ImemAddr); end
        Jump = 1'b1; JumpTarget = 32'h100;
        tick();
        Jump = 1'b0;
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin errors++; $display("FAIL jp_hold: got req=%0b addr=%h want 1/00000008", ImemReq, ImemAddr); end
        tick();
        checks++; if (ImemAddr !== 32'h8) begin errors++; $display("FAIL jp_hold2: got addr=%h want 00000008", ImemAddr); end
        ImemAck = 1'b1; ImemData = 32'hDEAD_0008;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100 || InstrValid !== 1'b0) begin errors++; $display("FAIL jp_drop: got req=%0b addr=%h v=%0b want 1/00000100/0", ImemReq, ImemAddr, InstrValid); end
        ImemData = 32'h1111_0100;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b1 || InstrPc !== 32'h100 || Instr !== 32'h1111_0100) begin errors++; $display("FAIL jp_target: got v=%0b pc=%h instr=%h want 1/00000100/11110100", InstrValid, InstrPc, Instr); end
    endtask

    task automatic test_fetch_redirect();
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h104) begin errors++; $display("FAIL fr_fetch: got req=%0b addr=%h want 1/00000104", ImemReq, ImemAddr); end
        BranchTaken = 1'b1; BranchTarget = 32'h180; ImemAck = 1'b1; ImemData = 32'hDEAD_0104;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h180 || InstrValid !== 1'b0) begin errors++; $display("FAIL fr_ack_redirect: got req=%0b addr=%h v=%0b want 1/00000180/0", ImemReq, ImemAddr, InstrValid); end
        BranchTaken = 1'b0; ImemAck = 1'b0; Jump = 1'b1; JumpTarget = 32'h240;
        tick();
        Jump = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h280;
        tick();
        checks++; if (ImemAddr !== 32'h180) begin errors++; $display("FAIL fr_pend_hold: got addr=%h want 00000180", ImemAddr); end
        BranchTaken = 1'b0; ImemAck = 1'b1; ImemData = 32'hDEAD_0180;
        tick();
        checks++; if (ImemAddr !== 32'h280 || InstrValid !== 1'b0 || ImemReq !== 1'b1) begin errors++; $display("FAIL fr_overwrite: got addr=%h v=%0b req=%0b want 00000280/0/1", ImemAddr, InstrValid, ImemReq); end
        ImemData = 32'h2222_0280;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b1 || InstrPc !== 32'h280 || Instr !== 32'h2222_0280) begin errors++; $display("FAIL fr_valid: got v=%0b pc=%h instr=%h want 1/00000280/22220280", InstrValid, InstrPc, Instr); end
    endtask

    task automatic test_priority();
        Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h200; BranchTaken = 1'b1; BranchTarget = 32'h300;
        tick();
        Jump = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
        checks++; if (ImemAddr !== 32'h200 || InstrValid !== 1'b0 || ImemReq !== 1'b1) begin errors++; $display("FAIL pri_jump_wins: got addr=%h v=%0b req=%0b want 00000200/0/1", ImemAddr, InstrValid, ImemReq); end
        checks++; if (AddrError !== 1'b0) begin errors++; $display("FAIL pri_no_err: got %0b want 0", AddrError); end
        ImemAck = 1'b1; ImemData = 32'h3333_0200;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b1 || InstrPc !== 32'h200) begin errors++; $display("FAIL pri_valid: got v=%0b pc=%h want 1/00000200", InstrValid, InstrPc); end
        BranchTaken = 1'b1; BranchTarget = 32'h302; Stall = 1'b1;
        tick();
        BranchTaken = 1'b0; Stall = 1'b0;
        checks++; if (ImemAddr !== 32'h300 || AddrError !== 1'b1 || InstrValid !== 1'b0) begin errors++; $display("FAIL pri_misalign: got addr=%h err=%0b v=%0b want 00000300/1/0", ImemAddr, AddrError, InstrValid); end
        tick();
        checks++; if (AddrError !== 1'b0 || ImemAddr !== 32'h300 || ImemReq !== 1'b1) begin errors++; $display("FAIL pri_err_pulse: got err=%0b addr=%h req=%0b want 0/00000300/1", AddrError, ImemAddr, ImemReq); end
    endtask

    task automatic test_idle_redirect();
        Enable = 1'b0; ImemAck = 1'b1; ImemData = 32'h4444_0300;
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid !== 1'b1 || InstrPc !== 32'h300 || Instr !== 32'h4444_0300) begin errors++; $display("FAIL idle_complete: got v=%0b pc=%h instr=%h want 1/00000300/44440300", InstrValid, InstrPc, Instr); end
        tick();
        checks++; if (ImemReq !== 1'b0 || InstrValid !== 1'b0 || ImemAddr !== 32'h304) begin errors++; $display("FAIL idle_enter: got req=%0b v=%0b addr=%h want 0/0/00000304", ImemReq, InstrValid, ImemAddr); end
        Jump = 1'b1; JumpTarget = 32'h401;
        tick();
        Jump = 1'b0;
        checks++; if (ImemAddr !== 32'h400 || AddrError !== 1'b1 || ImemReq !== 1'b0) begin errors++; $display("FAIL idle_redirect: got addr=%h err=%0b req=%0b want 00000400/1/0", ImemAddr, AddrError, ImemReq); end
        tick();
        checks++; if (AddrError !== 1'b0 || ImemReq !== 1'b0) begin errors++; $display("FAIL idle_stay: got err=%0b req=%0b want 0/0", AddrError, ImemReq); end
        Enable = 1'b1;
        tick();
        checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h400) begin errors++; $display("FAIL idle_resume: got req=%0b addr=%h want 1/00000400", ImemReq, ImemAddr); end
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        Enable = 1'b1;
        tick();
        checks++; if (ImemReq_b !== 1'b1 || ImemAddr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got req=%0b addr=%h want 1/fffffffc", ImemReq_b, ImemAddr_b); end
        ImemAck = 1'b1; ImemData = 32'h5555_AAAA;
        tick();
        ImemAck = 1'b0;
        checks++; if (ImemAddr_b !== 32'h0 || InstrPc_b !== 32'hFFFF_FFFC || AddrError_b !== 1'b0) begin errors++; $display("FAIL wrap_addr: got addr=%h pc=%h err=%0b want 00000000/fffffffc/0", ImemAddr_b, InstrPc_b, AddrError_b); end
        tick();
        checks++; if (ImemReq_b !== 1'b1 || ImemAddr_b !== 32'h0) begin errors++; $display("FAIL wrap_refetch: got req=%0b addr=%h want 1/00000000", ImemReq_b, ImemAddr_b); end
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (ImemReq_b !== 1'b0 || ImemAddr_b !== 32'hFFFF_FFFC || InstrValid_b !== 1'b0) begin errors++; $display("FAIL midfetch_rst: got req=%0b addr=%h v=%0b want 0/fffffffc/0", ImemReq_b, ImemAddr_b, InstrValid_b); end
        checks++; if (ImemReq !== 1'b0 || ImemAddr !== 32'h0) begin errors++; $display("FAIL midfetch_rst_a: got req=%0b addr=%h want 0/00000000", ImemReq, ImemAddr); end
        Enable = 1'b0; ImemAck = 1'b1; ImemData = 32'h7777_7777;
        @(negedge Clk) Rst_n = 1'b1;
        tick();
        tick();
        ImemAck = 1'b0;
        checks++; if (InstrValid_b !== 1'b0 || Instr_b !== 32'h0 || InstrPc_b !== 32'h0 || ImemReq_b !== 1'b0) begin errors++; $display("FAIL stale_ack: got v=%0b instr=%h pc=%h req=%0b want 0/0/0/0", InstrValid_b, Instr_b, InstrPc_b, ImemReq_b); end
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0) begin errors++; $display("FAIL stale_ack_a: got v=%0b instr=%h want 0/0", InstrValid, Instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump_pending();
        test_fetch_redirect();
        test_priority();
        test_idle_redirect();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter INC, default 32'd4, PC increment per fetched instruction.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 Enable  input  1  1 = fetching permitted; 0 = stop after current fetch.
REQ-006 Stall  input  1  1 = consumer not accepting Instr this cycle.
REQ-007 Jump  input  1  jump redirect request, single-cycle pulse.
REQ-008 JumpTarget  input  32  jump destination address.
REQ-009 BranchTaken  input  1  branch redirect request, single-cycle pulse.
REQ-010 BranchTarget  input  32  branch destination address.
REQ-011 ImemReq  output  1  fetch request to instruction memory.
REQ-012 ImemAddr  output  32  fetch address, equal to current PC register.
REQ-013 ImemAck  input  1  memory completes request; ImemData valid this cycle.
REQ-014 ImemData  input  32  instruction word from memory.
REQ-015 InstrValid  output  1  Instr/InstrPc hold a valid fetched instruction.
REQ-016 Instr  output  32  registered instruction word.
REQ-017 InstrPc  output  32  address Instr was fetched from.
REQ-018 AddrError  output  1  one-cycle pulse: redirect target not word-aligned.

Function
REQ-019 FSM states IDLE, FETCH, VALID; ImemReq SHALL be 1 exactly in FETCH, InstrValid exactly in VALID.
REQ-020 IDLE: Enable=1 -> FETCH next cycle; otherwise stay.
REQ-021 FETCH: ImemAddr and ImemReq SHALL stay stable until the ImemAck cycle.
REQ-022 FETCH, ImemAck=1, no redirect: Instr<=ImemData, InstrPc<=PC, PC<=PC+INC, -> VALID (InstrValid high the following cycle: 1-cycle latency from ack).
REQ-023 VALID: Stall=1 -> hold Instr/InstrPc/InstrValid; Stall=0 -> instruction consumed, -> FETCH if Enable=1, else IDLE.
REQ-024 Enable=0 in FETCH SHALL NOT abort the outstanding request; sequencer completes it and enters VALID.
REQ-025 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
REQ-026 Redirect = Jump or BranchTaken; Jump SHALL win when both asserted same cycle.
REQ-027 Redirect target bits[1:0] SHALL be forced to 0; if either was 1, AddrError=1 the next cycle for one cycle.
REQ-028 Redirect in IDLE: PC<=target, stay IDLE.
REQ-029 Redirect in VALID: PC<=target, InstrValid cleared next cycle regardless of Stall, -> FETCH if Enable=1, else IDLE.
REQ-030 Redirect in FETCH with ImemAck=1 same cycle: ImemData discarded, PC<=target, remain FETCH.
REQ-031 Redirect in FETCH without ImemAck: target stored as pending, address held; on ack data discarded, PC<=pending target, remain FETCH; later redirect before ack overwrites pending.
REQ-032 Discarded fetches SHALL never assert InstrValid.

Reset
REQ-033 Rst_n=0 SHALL immediately force: state IDLE, PC=ImemAddr=RESET_VECTOR, ImemReq=0, InstrValid=0, Instr=0, InstrPc=0, AddrError=0, pending redirect cleared.
REQ-034 Reset mid-fetch SHALL abandon the outstanding request; a subsequent ImemAck with no request SHALL be ignored.
REQ-035 Release of Rst_n takes effect at the next rising Clk; first fetch no earlier than one cycle after Enable=1 is sampled.

Verification
REQ-036 Reset, Enable=1, ImemAck every FETCH cycle, Stall=0 -> InstrPc sequence 0x0,0x4,0x8, ImemReq pattern 1,0 repeating.
REQ-037 Instr valid at InstrPc=0x8, Stall=1 for 3 cycles -> Instr/InstrPc/InstrValid unchanged, ImemReq=0 throughout.
REQ-038 Jump to 0x100 while FETCH at 0x8 awaits ack (ack 2 cycles later) -> data for 0x8 dropped, next InstrPc=0x100.
REQ-039 Jump=1 (0x200) and BranchTaken=1 (0x300) same cycle in VALID -> next ImemAddr=0x200; BranchTarget=0x302 alone -> ImemAddr=0x300, AddrError one-cycle pulse.
REQ-040 RESET_VECTOR=32'hFFFF_FFFC, one fetch acked -> ImemAddr wraps to 0x0; Rst_n low during FETCH -> ImemReq=0 and ImemAddr=0xFFFF_FFFC immediately.
